// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the 5-stage RISC-V core, placed beside ID.
//   - Detects load-use hazards and holds PC and IF/ID for LOAD_STALL_CYCLES
//     cycles, using an IDLE/STALL state machine and a 3-bit down-counter.
//   - Flushes IF/ID and ID/EX on a branch or jump resolved taken in EX. This
//     has priority over any stall and aborts a stall already in progress.
//   - Never treats x0 as a hazard source.
//   - Keeps a saturating count of stalled cycles for performance monitoring.
//
// Optional feature macro: HAZARD_FORWARD_EN
//   defined   : the block generates EX-stage forwarding selects, and only
//               load-use hazards stall.
//   undefined : forwards are tied to 00. A RAW hit against the EX or MEM
//               writer also stalls, for one cycle per hit.
//
// Ports:
//   clk, arst_n                  clock (rising edge), async active-low reset
//   rs1_ID, rs2_ID               sources of the instruction in ID
//   rs1_used_ID, rs2_used_ID     the source is actually read
//   rd_ID_EX, mem_read_ID_EX,
//   reg_write_ID_EX              destination and control of the EX instruction
//   rs1_ID_EX, rs2_ID_EX         EX operand sources (forwarding)
//   rd_EX_MEM, reg_write_EX_MEM  MEM-stage writer
//   rd_MEM_WB, reg_write_MEM_WB  WB-stage writer
//   branch_taken_EX              branch or jump resolved taken in EX
//   pc_write, IF_ID_write        PC and IF/ID enables
//   IF_ID_flush, ID_EX_flush     pipeline register clears
//   forward_a, forward_b         00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall_active                 a stall is applied this cycle
//   stall_count                  saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int PERF_W            = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [REG_ADDR_W-1:0] rs1_ID,
    input  logic [REG_ADDR_W-1:0] rs2_ID,
    input  logic                  rs1_used_ID,
    input  logic                  rs2_used_ID,
    input  logic [REG_ADDR_W-1:0] rd_ID_EX,
    input  logic                  mem_read_ID_EX,
    input  logic                  reg_write_ID_EX,
    input  logic [REG_ADDR_W-1:0] rs1_ID_EX,
    input  logic [REG_ADDR_W-1:0] rs2_ID_EX,
    input  logic [REG_ADDR_W-1:0] rd_EX_MEM,
    input  logic                  reg_write_EX_MEM,
    input  logic [REG_ADDR_W-1:0] rd_MEM_WB,
    input  logic                  reg_write_MEM_WB,
    input  logic                  branch_taken_EX,
    output logic                  pc_write,
    output logic                  IF_ID_write,
    output logic                  IF_ID_flush,
    output logic                  ID_EX_flush,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall_active,
    output logic [PERF_W-1:0]     stall_count
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Value loaded into the counter on entering STALL. The IDLE cycle that
    // detects the hazard is the first bubble, and STALL exits when cnt is 0.
    localparam logic [2:0] CNT_INIT = (LOAD_STALL_CYCLES > 1) ? 3'(LOAD_STALL_CYCLES - 2) : 3'd0;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

    // A register match counts only when the writer is enabled and is not x0.
    function automatic logic hit(input logic [REG_ADDR_W-1:0] r,
                                 input logic [REG_ADDR_W-1:0] rd,
                                 input logic                  we);
        return we && (rd != REG_ZERO) && (r == rd);
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    logic [PERF_W-1:0] r_stall_count;
    logic              w_lu_load;
    logic              w_lu;

    // A load in EX always writes its destination, so the write enable is implied.
    assign w_lu_load = mem_read_ID_EX &&
                       ((rs1_used_ID && hit(rs1_ID, rd_ID_EX, 1'b1)) ||
                        (rs2_used_ID && hit(rs2_ID, rd_ID_EX, 1'b1)));

`ifdef HAZARD_FORWARD_EN
    logic w_unused;

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
        logic [1:0] sel;
        if (hit(rs, rd_EX_MEM, reg_write_EX_MEM)) begin
            sel = 2'b10;
        end else if (hit(rs, rd_MEM_WB, reg_write_MEM_WB)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign w_lu     = w_lu_load;
    assign w_unused = reg_write_ID_EX;

    // Forwarding selects, forced to regfile while in reset.
    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (arst_n) begin
            forward_a = fwd_sel(rs1_ID_EX);
            forward_b = fwd_sel(rs2_ID_EX);
        end else begin
            forward_a = 2'b00;
            forward_b = 2'b00;
        end
    end
`else
    logic w_raw;
    logic w_unused;

    // Without forwarding, any pending write by EX or MEM to a source read in ID is a hazard.
    assign w_raw = (rs1_used_ID && (hit(rs1_ID, rd_ID_EX, reg_write_ID_EX) ||
                                    hit(rs1_ID, rd_EX_MEM, reg_write_EX_MEM))) ||
                   (rs2_used_ID && (hit(rs2_ID, rd_ID_EX, reg_write_ID_EX) ||
                                    hit(rs2_ID, rd_EX_MEM, reg_write_EX_MEM)));

    assign w_lu      = w_lu_load || w_raw;
    assign forward_a = 2'b00;
    assign forward_b = 2'b00;
    assign w_unused  = ^{rs1_ID_EX, rs2_ID_EX, rd_MEM_WB, reg_write_MEM_WB};
`endif

    // State, stall counter and performance counter registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 3'd0;
            r_stall_count <= {PERF_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (stall_active && (r_stall_count != {PERF_W{1'b1}})) begin
                r_stall_count <= r_stall_count + {{(PERF_W-1){1'b0}}, 1'b1};
            end else begin
                r_stall_count <= r_stall_count;
            end
        end
    end

    // Next-state logic. A taken branch overrides everything. Non-load hazards
    // never enter STALL.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (branch_taken_EX) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_lu_load && (LOAD_STALL_CYCLES > 1)) begin
                        w_state_nxt = ST_STALL;
                        w_cnt_nxt   = CNT_INIT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = r_cnt;
                    end
                end
                ST_STALL: begin
                    if (r_cnt == 3'd0) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = ST_STALL;
                        w_cnt_nxt   = r_cnt - 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    // Mealy control outputs. The pipeline runs freely while in reset.
    always_comb begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        stall_active = 1'b0;
        if (!arst_n) begin
            pc_write = 1'b1;
        end else if (branch_taken_EX) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if ((r_state == ST_STALL) || w_lu) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_flush  = 1'b1;
            stall_active = 1'b1;
        end else begin
            pc_write = 1'b1;
        end
    end

    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed self-checking bench for hazard_ctrl with LOAD_STALL_CYCLES=3 and
// PERF_W=4. Inputs change 1 ns after a rising edge. Mealy outputs are sampled
// 2 ns after the edge, well before the next edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       clk;
    logic       arst_n;
    logic [4:0] rs1_ID, rs2_ID, rd_ID_EX, rs1_ID_EX, rs2_ID_EX, rd_EX_MEM, rd_MEM_WB;
    logic       rs1_used_ID, rs2_used_ID, mem_read_ID_EX, reg_write_ID_EX;
    logic       reg_write_EX_MEM, reg_write_MEM_WB, branch_taken_EX;
    logic       pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, stall_active;
    logic [1:0] forward_a, forward_b;
    logic [3:0] stall_count;

    int n_checks;
    int n_errors;
    int exp_cnt;

    hazard_ctrl #(
        .REG_ADDR_W       (5),
        .LOAD_STALL_CYCLES(3),
        .PERF_W           (4)
    ) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .rs1_ID          (rs1_ID),
        .rs2_ID          (rs2_ID),
        .rs1_used_ID     (rs1_used_ID),
        .rs2_used_ID     (rs2_used_ID),
        .rd_ID_EX        (rd_ID_EX),
        .mem_read_ID_EX  (mem_read_ID_EX),
        .reg_write_ID_EX (reg_write_ID_EX),
        .rs1_ID_EX       (rs1_ID_EX),
        .rs2_ID_EX       (rs2_ID_EX),
        .rd_EX_MEM       (rd_EX_MEM),
        .reg_write_EX_MEM(reg_write_EX_MEM),
        .rd_MEM_WB       (rd_MEM_WB),
        .reg_write_MEM_WB(reg_write_MEM_WB),
        .branch_taken_EX (branch_taken_EX),
        .pc_write        (pc_write),
        .IF_ID_write     (IF_ID_write),
        .IF_ID_flush     (IF_ID_flush),
        .ID_EX_flush     (ID_EX_flush),
        .forward_a       (forward_a),
        .forward_b       (forward_b),
        .stall_active    (stall_active),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1_ID = 5'd0; rs2_ID = 5'd0; rs1_used_ID = 1'b0; rs2_used_ID = 1'b0;
        rd_ID_EX = 5'd0; mem_read_ID_EX = 1'b0; reg_write_ID_EX = 1'b0;
        rs1_ID_EX = 5'd0; rs2_ID_EX = 5'd0;
        rd_EX_MEM = 5'd0; reg_write_EX_MEM = 1'b0;
        rd_MEM_WB = 5'd0; reg_write_MEM_WB = 1'b0;
        branch_taken_EX = 1'b0;
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use5();
        mem_read_ID_EX = 1'b1; rd_ID_EX = 5'd5; rs1_ID = 5'd5; rs1_used_ID = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_cnt  = 0;
        arst_n   = 1'b0;
        clear_inputs();
        // While in reset, a hazard on the inputs must not stall the pipeline.
        set_load_use5();
        #2;
        check_eq("rst_pc_write", 32'(pc_write), 32'd1);
        check_eq("rst_stall_active", 32'(stall_active), 32'd0);
        check_eq("rst_stall_count", 32'(stall_count), 32'd0);
        check_eq("rst_forwards", 32'({forward_a, forward_b}), 32'd0);
        check_eq("rst_flush", 32'({IF_ID_flush, ID_EX_flush}), 32'd0);
        clear_inputs();
        #10 arst_n = 1'b1;
        next_cycle();

        // Load-use: exactly three stalled cycles. After the first cycle the
        // EX instruction is the inserted bubble.
        set_load_use5();
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("lu_pc_write_%0d", i), 32'(pc_write), 32'd0);
            check_eq($sformatf("lu_if_id_write_%0d", i), 32'(IF_ID_write), 32'd0);
            check_eq($sformatf("lu_id_ex_flush_%0d", i), 32'(ID_EX_flush), 32'd1);
            check_eq($sformatf("lu_stall_active_%0d", i), 32'(stall_active), 32'd1);
            next_cycle();
            clear_inputs();
        end
        exp_cnt = 3;
        #1;
        check_eq("lu_release_pc_write", 32'(pc_write), 32'd1);
        check_eq("lu_stall_count", 32'(stall_count), 32'(exp_cnt));

        // x0 is never a hazard source.
        mem_read_ID_EX = 1'b1; rd_ID_EX = 5'd0; rs1_ID = 5'd0; rs1_used_ID = 1'b1;
        #1;
        check_eq("x0_pc_write", 32'(pc_write), 32'd1);
        check_eq("x0_stall_active", 32'(stall_active), 32'd0);
        // An unused rs2 is not a hazard source.
        rs1_ID = 5'd1; rd_ID_EX = 5'd7; rs2_ID = 5'd7; rs2_used_ID = 1'b0;
        #1;
        check_eq("unused_rs2_pc_write", 32'(pc_write), 32'd1);
        // The same operand, now read, stalls.
        rs2_used_ID = 1'b1;
        #1;
        check_eq("used_rs2_pc_write", 32'(pc_write), 32'd0);
        next_cycle();
        exp_cnt++;
        clear_inputs();

        // Branch abort: now in STALL with cnt=1.
        branch_taken_EX = 1'b1;
        #1;
        check_eq("br_if_id_flush", 32'(IF_ID_flush), 32'd1);
        check_eq("br_id_ex_flush", 32'(ID_EX_flush), 32'd1);
        check_eq("br_pc_write", 32'(pc_write), 32'd1);
        check_eq("br_stall_active", 32'(stall_active), 32'd0);
        next_cycle();
        clear_inputs();
        #1;
        check_eq("br_after_pc_write", 32'(pc_write), 32'd1);
        check_eq("br_after_flush", 32'(IF_ID_flush), 32'd0);
        check_eq("br_stall_count", 32'(stall_count), 32'(exp_cnt));

`ifdef HAZARD_FORWARD_EN
        // Forwarding priority: EX/MEM wins over MEM/WB.
        rs1_ID_EX = 5'd3; rd_EX_MEM = 5'd3; rd_MEM_WB = 5'd3;
        reg_write_EX_MEM = 1'b1; reg_write_MEM_WB = 1'b1;
        #1;
        check_eq("fwd_a_exmem", 32'(forward_a), 32'd2);
        check_eq("fwd_b_none", 32'(forward_b), 32'd0);
        reg_write_EX_MEM = 1'b0;
        #1;
        check_eq("fwd_a_memwb", 32'(forward_a), 32'd1);
        rs2_ID_EX = 5'd3; rd_MEM_WB = 5'd0;
        reg_write_EX_MEM = 1'b1;
        #1;
        check_eq("fwd_a_x0_memwb_exmem", 32'(forward_a), 32'd2);
        check_eq("fwd_b_exmem", 32'(forward_b), 32'd2);
        clear_inputs();
        // A non-load RAW hit is resolved by forwarding and does not stall.
        reg_write_ID_EX = 1'b1; rd_ID_EX = 5'd9; rs2_ID = 5'd9; rs2_used_ID = 1'b1;
        #1;
        check_eq("fwd_raw_no_stall", 32'(pc_write), 32'd1);
        next_cycle();
        clear_inputs();
`else
        // Without forwarding, a non-load RAW hit stalls for one cycle only.
        reg_write_ID_EX = 1'b1; rd_ID_EX = 5'd9; rs2_ID = 5'd9; rs2_used_ID = 1'b1;
        rs1_ID_EX = 5'd9; rd_EX_MEM = 5'd9; reg_write_MEM_WB = 1'b1; rd_MEM_WB = 5'd9;
        #1;
        check_eq("raw_ex_pc_write", 32'(pc_write), 32'd0);
        check_eq("raw_ex_stall_active", 32'(stall_active), 32'd1);
        check_eq("raw_forwards", 32'({forward_a, forward_b}), 32'd0);
        next_cycle();
        exp_cnt++;
        clear_inputs();
        #1;
        check_eq("raw_ex_one_cycle", 32'(pc_write), 32'd1);
        // A RAW hit against the MEM-stage writer also stalls.
        reg_write_EX_MEM = 1'b1; rd_EX_MEM = 5'd4; rs1_ID = 5'd4; rs1_used_ID = 1'b1;
        #1;
        check_eq("raw_mem_pc_write", 32'(pc_write), 32'd0);
        next_cycle();
        exp_cnt++;
        clear_inputs();
        #1;
        check_eq("raw_mem_one_cycle", 32'(pc_write), 32'd1);
        check_eq("raw_stall_count", 32'(stall_count), 32'(exp_cnt));
`endif

        // Saturation: hold the hazard for 19 cycles, which leaves the FSM in STALL with cnt=1.
        set_load_use5();
        for (int i = 0; i < 19; i++) begin
            #1;
            check_eq($sformatf("hold_stall_%0d", i), 32'(stall_active), 32'd1);
            next_cycle();
        end
        #1;
        check_eq("sat_stall_count", 32'(stall_count), 32'd15);
        clear_inputs();
        #1;
        check_eq("sat_in_stall_pc_write", 32'(pc_write), 32'd0);
        // Assert reset away from any clock edge. The effect must be immediate.
        arst_n = 1'b0;
        #1;
        check_eq("mid_rst_stall_count", 32'(stall_count), 32'd0);
        check_eq("mid_rst_pc_write", 32'(pc_write), 32'd1);
        check_eq("mid_rst_stall_active", 32'(stall_active), 32'd0);
        #1 arst_n = 1'b1;
        next_cycle();
        #1;
        check_eq("post_rst_idle_pc_write", 32'(pc_write), 32'd1);
        check_eq("post_rst_stall_count", 32'(stall_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
